// File: rtl/servis_uart_pkg.sv
// Shared types and constants for the servis UART receiver.
// The PARITY state is always encoded; it is only entered when SERVIS_UART_RX_PARITY_EN is defined.
package servis_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Width helper that never returns zero, so one-entry ranges still get a real bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/servis_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy-count full/empty.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module servis_rx_fifo
    import servis_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && i_ready;
    assign w_push_ok = i_push && (!w_full || w_pop);

    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_drop  = i_push && !w_push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/servis_uart_rx.sv
// 8N1 UART receiver feeding a small FWFT FIFO with framing/overrun pulses.
// Define SERVIS_UART_RX_PARITY_EN for 8E1 frames and the o_parity_err output.
module servis_uart_rx
    import servis_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun
`ifdef SERVIS_UART_RX_PARITY_EN
    ,
    output logic                 o_parity_err
`endif
);

    localparam int CW = clog2_min1(CLKS_PER_BIT);
    localparam int IW = clog2_min1(DATA_BITS);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nx;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_expire;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_frame_err_nx;
    logic                 r_frame_err;
    logic                 r_overrun;
`ifdef SERVIS_UART_RX_PARITY_EN
    logic                 r_par;
    logic                 w_par_nx;
    logic                 w_parity_err_nx;
    logic                 r_parity_err;
`endif

    assign w_rx_s   = r_sync2;
    assign w_expire = (r_cnt == '0);

    // Synchroniser presets to 1 so a reset never looks like a start bit.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_shift     <= w_shift_nx;
            r_frame_err <= w_frame_err_nx;
            r_overrun   <= w_drop;
        end
    end

`ifdef SERVIS_UART_RX_PARITY_EN
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par        <= w_par_nx;
            r_parity_err <= w_parity_err_nx;
        end
    end
    assign o_parity_err = r_parity_err;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = w_expire ? r_cnt : r_cnt - 1'b1;
        w_idx_nx       = r_idx;
        w_shift_nx     = r_shift;
        w_push         = 1'b0;
        w_frame_err_nx = 1'b0;
`ifdef SERVIS_UART_RX_PARITY_EN
        w_par_nx        = r_par;
        w_parity_err_nx = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nx = START;
                    w_cnt_nx   = HALF_BIT;
                end
            end
            START: begin
                if (w_expire) begin
                    if (w_rx_s) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = DATA;
                        w_idx_nx   = '0;
                        w_cnt_nx   = FULL_BIT;
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nx   = FULL_BIT;
                    w_idx_nx   = r_idx + 1'b1;
                    if (r_idx == IW'(DATA_BITS - 1)) begin
`ifdef SERVIS_UART_RX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end
                end
            end
`ifdef SERVIS_UART_RX_PARITY_EN
            PARITY: begin
                if (w_expire) begin
                    w_par_nx   = w_rx_s;
                    w_cnt_nx   = FULL_BIT;
                    w_state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (w_expire) begin
                    if (w_rx_s) begin
                        w_state_nx = IDLE;
`ifdef SERVIS_UART_RX_PARITY_EN
                        if (^{r_shift, r_par}) begin
                            w_parity_err_nx = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
`else
                        w_push = 1'b1;
`endif
                    end else begin
                        // A low stop bit wins over any parity problem on the same frame.
                        w_frame_err_nx = 1'b1;
                        w_state_nx     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    servis_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_drop  (w_drop)
    );

    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_servis_uart_rx.sv
// Bench for servis_uart_rx: directed frames plus random traffic checked against a frame-level model.
// Handshake: a byte moves when o_valid && i_ready are both high at a clock edge.
module tb_servis_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef SERVIS_UART_RX_PARITY_EN
    localparam int  NBITS     = 10;
    localparam bit  PARITY_ON = 1'b1;
`else
    localparam int  NBITS     = 9;
    localparam bit  PARITY_ON = 1'b0;
`endif
    // Drive-to-visible: two synchroniser flops, one cycle to see the start,
    // half a bit to the start-bit middle, then NBITS whole bits to the stop-bit middle.
    localparam int LAT = 3 + CPB / 2 + NBITS * CPB;

    logic       wb_clk  = 1'b0;
    logic       wb_rst  = 1'b1;
    logic       i_rx    = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
`ifdef SERVIS_UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    servis_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
`ifdef SERVIS_UART_RX_PARITY_EN
        ,
        .o_parity_err (o_parity_err)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int         cnt_fe = 0, cnt_ov = 0, cnt_pe = 0, cnt_both = 0;
    int         last_start = 0;
    bit         chk_lat    = 1'b0;
    bit         rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (o_frame_err) cnt_fe++;
            if (o_overrun) cnt_ov++;
            if (o_frame_err && o_overrun) cnt_both++;
`ifdef SERVIS_UART_RX_PARITY_EN
            if (o_parity_err) cnt_pe++;
            if (o_parity_err && (o_frame_err || o_overrun)) cnt_both++;
`endif
            if (prev_stall && o_valid) check_eq("data_stable", o_data, prev_data);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_byte", o_valid, 1'b0);
                else check_eq("rx_byte", o_data, exp_q.pop_front());
            end
            if (chk_lat && o_valid && !prev_valid) check_eq("latency", cyc - last_start, LAT);
            prev_stall = o_valid && !i_ready;
            prev_valid = o_valid;
            prev_data  = o_data;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    always @(posedge wb_clk) begin
        if (rand_ready) begin
            #1 i_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    // Frame-level model: decides what a completed frame should do to the outputs.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                               input logic pulse_pop);
        logic par_fail;
        par_fail = bad_par & PARITY_ON;
        if (!stop_bit) exp_fe++;
        else if (par_fail) exp_pe++;
        else if (exp_q.size() < DEPTH || pulse_pop) exp_q.push_back(b);
        else exp_ov++;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                              input logic pulse_pop, input int low_hold);
        int start;
        @(posedge wb_clk);
        #1;
        start      = cyc;
        last_start = start;
        i_rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            hold(CPB);
        end
        if (PARITY_ON) begin
            i_rx = (^b) ^ bad_par;
            hold(CPB);
        end
        i_rx = stop_bit;
        for (int c = 0; c < CPB; c++) begin
            if (c == CPB / 2) model_frame(b, stop_bit, bad_par, pulse_pop);
            @(posedge wb_clk);
            #1;
            // Ready high only during the cycle in which the byte is pushed.
            if (pulse_pop) i_ready = (cyc == start + LAT - 1);
        end
        if (!stop_bit) begin
            hold(low_hold);
            i_rx = 1'b1;
            hold(4);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) hold(1);
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_frame_err"}, cnt_fe, exp_fe);
        check_eq({tag, "_overrun"}, cnt_ov, exp_ov);
        check_eq({tag, "_parity_err"}, cnt_pe, exp_pe);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        logic       stop_b;
        logic       bad_p;

        wb_rst = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_data", o_data, 8'h00);
        check_eq("rst_frame_err", o_frame_err, 1'b0);
        check_eq("rst_overrun", o_overrun, 1'b0);
        wb_rst = 1'b0;
        hold(4);

        // Two good frames, consumer always ready, latency checked on each.
        i_ready = 1'b1;
        chk_lat = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 0);
        hold(4);
        chk_lat = 1'b0;
        check_eq("two_frames_left", exp_q.size(), 0);
        check_counts("two_frames");

        // Glitch shorter than half a bit is a false start.
        i_rx = 1'b0;
        hold(5);
        i_rx = 1'b1;
        hold(CPB * 12);
        check_eq("false_start_valid", o_valid, 1'b0);
        check_counts("false_start");

        // Low stop bit followed by a long break: one frame error only.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 100);
        hold(4);
        check_counts("break");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
        hold(4);
        wait_drain();

        // Consumer stalled: fifth byte overflows.
        i_ready = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, 1'b0, 0);
        hold(4);
        check_counts("overrun");
        check_eq("full_valid", o_valid, 1'b1);
        check_eq("full_head", o_data, exp_q[0]);
        i_ready = 1'b1;
        wait_drain();
        hold(2);
        check_eq("overrun_empty", o_valid, 1'b0);

        // Full FIFO with a pop in the push cycle: nothing dropped.
        i_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h06, 1'b1, 1'b0, 1'b1, 0);
        hold(4);
        check_counts("push_pop_full");
        i_ready = 1'b1;
        wait_drain();
        hold(2);
        check_eq("push_pop_empty", o_valid, 1'b0);

        // Reset in the middle of a frame with a byte waiting in the FIFO.
        i_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        hold(4);
        check_eq("pre_rst_valid", o_valid, 1'b1);
        i_rx = 1'b0;
        hold(CPB);
        i_rx = 1'b1;
        hold(CPB * 4);
        #3;
        wb_rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("async_rst_valid", o_valid, 1'b0);
        check_eq("async_rst_data", o_data, 8'h00);
        check_eq("async_rst_frame_err", o_frame_err, 1'b0);
        check_eq("async_rst_overrun", o_overrun, 1'b0);
        hold(3);
        wb_rst = 1'b0;
        hold(4);
        i_ready = 1'b1;
        chk_lat = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 0);
        hold(4);
        chk_lat = 1'b0;
        wait_drain();

        if (PARITY_ON) begin
            send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0);
            send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
            hold(4);
            wait_drain();
            check_counts("parity");
        end

        // Random traffic with a randomly stalling consumer.
        rand_ready = 1'b1;
        repeat (24) begin
            b      = 8'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            bad_p  = ($urandom_range(0, 7) == 0);
            send_frame(b, stop_b, bad_p, 1'b0, $urandom_range(0, 40));
            hold($urandom_range(0, 20));
        end
        rand_ready = 1'b0;
        hold(2);
        i_ready = 1'b1;
        wait_drain();
        hold(4);

        check_counts("final");
        check_eq("final_exclusive_pulses", cnt_both, 0);
        check_eq("final_valid", o_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
